// File: rtl/keypad_scanner_4x4_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

    localparam logic [3:0] COL_IDLE = 4'b1111;

    localparam logic [3:0] KEY_MAP [0:3][0:3] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'hE, 4'h0, 4'hF, 4'hD}
    };

    // Active-low one-hot drive pattern for a column index.
    function automatic logic [3:0] col_drive(input logic [1:0] idx);
        return COL_IDLE & ~(4'b0001 << idx);
    endfunction

    // Index of the lowest row reading low; callers guarantee at least one is low.
    function automatic logic [1:0] lowest_low(input logic [3:0] rows);
        logic [1:0] idx;
        idx = 2'd3;
        for (int i = 3; i >= 0; i--) begin
            if (!rows[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scanner_4x4_if.sv
// Keypad matrix pins plus the key stream toward the display stage.
interface keypad_scanner_4x4_if;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    modport master (input row_in, output col_out, key_code, key_valid, key_held);
    modport slave  (output row_in, input col_out, key_code, key_valid, key_held);
endinterface

// File: rtl/keypad_scanner_4x4_sync_2ff.sv
// Two-flop synchronizer, resets to all-ones (idle level of pulled-up rows).
module sync_2ff #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);
    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= '1;
            r_sync <= '1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;
endmodule

// File: rtl/keypad_scanner_4x4.sv
// 4x4 keypad scanner: column scan, press/release debounce, hex encoding.
// Rows carry 2 cycles of sync latency; no backpressure, key_valid is a one-cycle strobe.
module keypad_scanner_4x4
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int CNT_W           = 20
) (
    input  logic                 clk,
    input  logic                 rst,
    keypad_scanner_4x4_if.master kp
);
    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       w_rs;
    logic             w_sel_row;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [1:0]       w_cidx_nxt;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_cidx;
    logic [1:0]       r_rsel;
    logic [3:0]       r_col;
    logic [3:0]       r_code;
    logic             r_valid;
    logic             r_held;

    sync_2ff #(.WIDTH(4)) u_row_sync (
        .clk (clk),
        .rst (rst),
        .i_d (kp.row_in),
        .o_q (w_rs)
    );

    assign w_sel_row  = w_rs[r_rsel];
    assign w_cidx_nxt = r_cidx + 2'd1;
    assign w_cnt_inc  = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= SCAN;
            r_cnt   <= '0;
            r_cidx  <= 2'd0;
            r_rsel  <= 2'd0;
            r_col   <= col_drive(2'd0);
            r_code  <= 4'h0;
            r_valid <= 1'b0;
            r_held  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                SCAN: begin
                    if (r_cnt >= SCAN_LAST) begin
                        r_cnt <= '0;
                        if (w_rs != COL_IDLE) begin
                            r_rsel  <= lowest_low(w_rs);
                            r_state <= DEBOUNCE;
                        end else begin
                            r_cidx <= w_cidx_nxt;
                            r_col  <= col_drive(w_cidx_nxt);
                        end
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                DEBOUNCE: begin
                    if (w_sel_row) begin
                        r_cnt   <= '0;
                        r_cidx  <= w_cidx_nxt;
                        r_col   <= col_drive(w_cidx_nxt);
                        r_state <= SCAN;
                    end else if (r_cnt >= DB_LAST) begin
                        r_cnt   <= '0;
                        r_code  <= KEY_MAP[r_rsel][r_cidx];
                        r_valid <= 1'b1;
                        r_held  <= 1'b1;
                        r_state <= HELD;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                HELD: begin
                    // Column stays frozen so only the accepted key's row matters.
                    if (w_sel_row) begin
                        r_cnt   <= '0;
                        r_state <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (!w_sel_row) begin
                        r_state <= HELD;
                    end else if (r_cnt >= DB_LAST) begin
                        r_cnt   <= '0;
                        r_held  <= 1'b0;
                        r_cidx  <= w_cidx_nxt;
                        r_col   <= col_drive(w_cidx_nxt);
                        r_state <= SCAN;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                default: r_state <= SCAN;
            endcase
        end
    end

    assign kp.col_out   = r_col;
    assign kp.key_code  = r_code;
    assign kp.key_valid = r_valid;
    assign kp.key_held  = r_held;
endmodule

// File: tb/tb_keypad_scanner_4x4.sv
// Randomized and directed bench for keypad_scanner_4x4 with a keypad matrix model and display model.
module tb_keypad_scanner_4x4;
    localparam int SD = 4;
    localparam int DB = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    keypad_scanner_4x4_if kp ();

    keypad_scanner_4x4 #(
        .SCAN_DIV        (SD),
        .DEBOUNCE_CYCLES (DB),
        .CNT_W           (20)
    ) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kp)
    );

    int checks = 0;
    int errors = 0;

    // Physical keypad: a pressed key shorts its row to its column.
    logic [15:0] pressed = 16'h0;
    logic [3:0]  rows;
    always_comb begin
        rows = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !kp.col_out[c]) rows[r] = 1'b0;
    end
    assign kp.row_in = rows;

    int unsigned ref_map [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

    int          cyc = 0;
    int          pulses = 0;
    int          last_pulse = -1;
    logic [23:0] disp = 24'h0;
    logic [23:0] exp_disp = 24'h0;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            last_pulse = -1;
        end else if (kp.key_valid) begin
            pulses++;
            disp = {disp[19:0], kp.key_code};
            if (last_pulse >= 0) begin
                checks++;
                if (cyc - last_pulse < 2*DB + SD) begin
                    errors++;
                    $display("FAIL pulse_spacing got %0d cycles want >= %0d", cyc - last_pulse, 2*DB + SD);
                end
            end
            last_pulse = cyc;
        end
    end

    task automatic press_release(input logic [15:0] mask, input int hold, input int rel);
        pressed = mask;
        repeat (hold) @(negedge clk);
        pressed = 16'h0;
        repeat (rel) @(negedge clk);
    endtask

    task automatic test_reset;
        logic [3:0] want;
        logic       saw_valid;
        rst = 1'b1;
        pressed = 16'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checks++;
        if (kp.col_out !== 4'b1110 || kp.key_code !== 4'h0 || kp.key_valid !== 1'b0 || kp.key_held !== 1'b0) begin
            errors++;
            $display("FAIL reset_values got col=%b code=%h v=%b h=%b want col=1110 code=0 v=0 h=0",
                     kp.col_out, kp.key_code, kp.key_valid, kp.key_held);
        end
        saw_valid = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (k % 4 == 0) begin
                want = ~(4'b0001 << ((k / 4) % 4));
                checks++;
                if (kp.col_out !== want) begin
                    errors++;
                    $display("FAIL scan_rotate k=%0d got %b want %b", k, kp.col_out, want);
                end
            end
            if (kp.key_valid) saw_valid = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (saw_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_valid got 1 want 0");
        end
    endtask

    task automatic test_single_press;
        int p0;
        p0 = pulses;
        pressed = 16'h1 << (1*4 + 1);
        repeat (60) @(negedge clk);
        exp_disp = {exp_disp[19:0], 4'(ref_map[5])};
        checks++;
        if (pulses - p0 != 1) begin
            errors++;
            $display("FAIL single_pulses got %0d want 1", pulses - p0);
        end
        checks++;
        if (kp.key_code !== 4'(ref_map[5]) || kp.key_held !== 1'b1) begin
            errors++;
            $display("FAIL single_code got code=%h held=%b want code=5 held=1", kp.key_code, kp.key_held);
        end
        pressed = 16'h0;
        repeat (8) @(negedge clk);
        checks++;
        if (kp.key_held !== 1'b1) begin
            errors++;
            $display("FAIL single_held_early got %b want 1", kp.key_held);
        end
        repeat (6) @(negedge clk);
        checks++;
        if (kp.key_held !== 1'b0) begin
            errors++;
            $display("FAIL single_held_drop got %b want 0", kp.key_held);
        end
        repeat (30) @(negedge clk);
        checks++;
        if (pulses - p0 != 1) begin
            errors++;
            $display("FAIL single_extra_pulse got %0d want 1", pulses - p0);
        end
    endtask

    task automatic test_short_bounce;
        int p0;
        int budget;
        p0 = pulses;
        budget = 0;
        while (kp.col_out === 4'b1110 && budget < 100) begin @(negedge clk); budget++; end
        while (kp.col_out !== 4'b1110 && budget < 100) begin @(negedge clk); budget++; end
        checks++;
        if (budget >= 100) begin
            errors++;
            $display("FAIL bounce_wait_col0 got timeout want col0 within 100 cycles");
        end
        pressed = 16'h1 << (2*4 + 0);
        repeat (5) @(negedge clk);
        pressed = 16'h0;
        @(negedge clk);
        checks++;
        if (kp.col_out !== 4'b1110) begin
            errors++;
            $display("FAIL bounce_col_frozen got %b want 1110", kp.col_out);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (kp.col_out !== 4'b1101) begin
            errors++;
            $display("FAIL bounce_resume_col1 got %b want 1101", kp.col_out);
        end
        repeat (30) @(negedge clk);
        checks++;
        if (pulses != p0 || kp.key_code !== 4'h5 || kp.key_held !== 1'b0) begin
            errors++;
            $display("FAIL bounce_no_pulse got pulses=%0d code=%h held=%b want pulses=0 code=5 held=0",
                     pulses - p0, kp.key_code, kp.key_held);
        end
    endtask

    task automatic test_code_map;
        int keys [4] = '{12, 14, 15, 3};
        int p0;
        logic [3:0] want;
        for (int i = 0; i < 4; i++) begin
            p0 = pulses;
            want = 4'(ref_map[keys[i]]);
            press_release(16'h1 << keys[i], 40, 25);
            exp_disp = {exp_disp[19:0], want};
            checks++;
            if (pulses - p0 != 1 || kp.key_code !== want) begin
                errors++;
                $display("FAIL code_map key=%0d got pulses=%0d code=%h want pulses=1 code=%h",
                         keys[i], pulses - p0, kp.key_code, want);
            end
        end
        checks++;
        if (disp !== exp_disp) begin
            errors++;
            $display("FAIL display_digits got %h want %h", disp, exp_disp);
        end
    endtask

    task automatic test_release_bounce;
        int p0;
        logic [15:0] k9;
        k9 = 16'h1 << (2*4 + 2);
        p0 = pulses;
        pressed = k9;
        repeat (40) @(negedge clk);
        exp_disp = {exp_disp[19:0], 4'(ref_map[10])};
        checks++;
        if (kp.key_code !== 4'h9 || pulses - p0 != 1) begin
            errors++;
            $display("FAIL relbounce_accept got code=%h pulses=%0d want code=9 pulses=1", kp.key_code, pulses - p0);
        end
        for (int i = 0; i < 4; i++) begin
            pressed = 16'h0;
            repeat (3) @(negedge clk);
            pressed = k9;
            repeat (3) @(negedge clk);
            checks++;
            if (kp.key_held !== 1'b1) begin
                errors++;
                $display("FAIL relbounce_held_%0d got %b want 1", i, kp.key_held);
            end
        end
        pressed = 16'h0;
        repeat (9) @(negedge clk);
        checks++;
        if (kp.key_held !== 1'b1) begin
            errors++;
            $display("FAIL relbounce_held_before got %b want 1", kp.key_held);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (kp.key_held !== 1'b0) begin
            errors++;
            $display("FAIL relbounce_held_after got %b want 0", kp.key_held);
        end
        repeat (20) @(negedge clk);
        checks++;
        if (pulses - p0 != 1) begin
            errors++;
            $display("FAIL relbounce_pulses got %0d want 1", pulses - p0);
        end
    endtask

    task automatic test_priority;
        int p0;
        p0 = pulses;
        press_release((16'h1 << (0*4 + 2)) | (16'h1 << (2*4 + 2)), 40, 25);
        exp_disp = {exp_disp[19:0], 4'(ref_map[2])};
        checks++;
        if (pulses - p0 != 1 || kp.key_code !== 4'h3) begin
            errors++;
            $display("FAIL priority got pulses=%0d code=%h want pulses=1 code=3", pulses - p0, kp.key_code);
        end
    endtask

    task automatic test_random;
        int p0;
        int k;
        logic [3:0] want;
        for (int i = 0; i < 8; i++) begin
            k = int'($urandom_range(0, 15));
            want = 4'(ref_map[k]);
            p0 = pulses;
            press_release(16'h1 << k, 40, 25);
            exp_disp = {exp_disp[19:0], want};
            checks++;
            if (pulses - p0 != 1 || kp.key_code !== want || kp.key_held !== 1'b0) begin
                errors++;
                $display("FAIL random_key idx=%0d key=%0d got pulses=%0d code=%h held=%b want pulses=1 code=%h held=0",
                         i, k, pulses - p0, kp.key_code, kp.key_held, want);
            end
        end
        checks++;
        if (disp !== exp_disp) begin
            errors++;
            $display("FAIL random_display got %h want %h", disp, exp_disp);
        end
    endtask

    task automatic test_reset_mid_debounce;
        int p0;
        p0 = pulses;
        rst = 1'b1;
        pressed = 16'h1 << (1*4 + 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (kp.col_out !== 4'b1110 || kp.key_code !== 4'h0 || kp.key_valid !== 1'b0 || kp.key_held !== 1'b0) begin
            errors++;
            $display("FAIL midreset_values got col=%b code=%h v=%b h=%b want col=1110 code=0 v=0 h=0",
                     kp.col_out, kp.key_code, kp.key_valid, kp.key_held);
        end
        pressed = 16'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        checks++;
        if (pulses != p0 || kp.key_code !== 4'h0) begin
            errors++;
            $display("FAIL midreset_no_pulse got pulses=%0d code=%h want pulses=0 code=0", pulses - p0, kp.key_code);
        end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_short_bounce();
        test_code_map();
        test_release_bounce();
        test_priority();
        test_random();
        test_reset_mid_debounce();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
